// File: rtl/thread_scheduler.sv
// thread_scheduler: four-thread round-robin issue scheduler.
// Holds per-thread PCs and run state and presents one PC and thread ID
// per unstalled cycle to instruction fetch. The execute stage can
// redirect a thread's PC or halt a thread.
module thread_scheduler #(
   parameter int INSTMEM_LOG2_DEEP = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [3:0]                   thread_en_i,
   input  logic                         stall_i,
   input  logic                         redirect_valid_i,
   input  logic [1:0]                   redirect_thread_i,
   input  logic [INSTMEM_LOG2_DEEP-1:0] redirect_pc_i,
   input  logic                         halt_valid_i,
   input  logic [1:0]                   halt_thread_i,
   output logic                         issue_valid_o,
   output logic [1:0]                   issue_thread_o,
   output logic [INSTMEM_LOG2_DEEP-1:0] issue_pc_o,
   output logic [3:0]                   running_o,
   output logic                         idle_o
);

   localparam int W = INSTMEM_LOG2_DEEP;
   localparam logic [W-1:0] PC_ONE = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } thr_state_e;

   thr_state_e     state_r     [4];
   thr_state_e     state_nxt_s [4];
   logic [W-1:0]   pc_r        [4];
   logic [W-1:0]   pc_nxt_s    [4];
   logic [1:0]     last_r;

   logic [3:0]     run_s;
   logic [3:0]     halt_hit_s;
   logic [3:0]     elig_s;
   logic [1:0]     cand_s;
   logic [1:0]     sel_s;
   logic           sel_valid_s;
   logic           issue_s;
   logic           redir_ok_s;
   logic           redir_sel_s;

   // Each thread starts in its own quarter of instruction memory.
   function automatic logic [W-1:0] start_pc(input logic [1:0] t);
      return {t, {(W-2){1'b0}}};
   endfunction

   // Decode run state and same-cycle halts into the eligible set.
   always_comb begin
      run_s      = 4'b0000;
      halt_hit_s = 4'b0000;
      for (int t = 0; t < 4; t++) begin
         run_s[t]      = (state_r[t] == ST_RUN);
         halt_hit_s[t] = halt_valid_i && (halt_thread_i == 2'(t));
      end
      elig_s = run_s & ~halt_hit_s;
   end

   // Round-robin pick: scan last+1 .. last+4 and take the first eligible.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_s       = last_r;
      cand_s      = last_r;
      for (int k = 1; k <= 4; k++) begin
         cand_s = last_r + 2'(k);
         if (!sel_valid_s && elig_s[cand_s]) begin
            sel_valid_s = 1'b1;
            sel_s       = cand_s;
         end else begin
            // an earlier candidate already won; keep it
         end
      end
      issue_s     = !stall_i && sel_valid_s;
      redir_ok_s  = redirect_valid_i && elig_s[redirect_thread_i];
      redir_sel_s = redir_ok_s && issue_s && (redirect_thread_i == sel_s);
   end

   // Next thread state and next PC for every thread.
   always_comb begin
      for (int t = 0; t < 4; t++) begin
         state_nxt_s[t] = state_r[t];
         pc_nxt_s[t]    = pc_r[t];
         // a redirect that lands on the issuing thread is bypassed, so the
         // stored PC already points past the redirect target
         if (redir_ok_s && (redirect_thread_i == 2'(t))) begin
            pc_nxt_s[t] = redir_sel_s ? (redirect_pc_i + PC_ONE) : redirect_pc_i;
         end else if (issue_s && (sel_s == 2'(t))) begin
            pc_nxt_s[t] = pc_r[t] + PC_ONE;
         end else begin
            pc_nxt_s[t] = pc_r[t];
         end
         // dropping the enable always kills the thread, even over a halt
         case (state_r[t])
            ST_IDLE: begin
               if (thread_en_i[t]) begin
                  state_nxt_s[t] = ST_RUN;
                  pc_nxt_s[t]    = start_pc(2'(t));
               end else begin
                  state_nxt_s[t] = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (!thread_en_i[t]) begin
                  state_nxt_s[t] = ST_IDLE;
               end else if (halt_hit_s[t]) begin
                  state_nxt_s[t] = ST_HALTED;
               end else begin
                  state_nxt_s[t] = ST_RUN;
               end
            end
            ST_HALTED: begin
               if (!thread_en_i[t]) begin
                  state_nxt_s[t] = ST_IDLE;
               end else begin
                  state_nxt_s[t] = ST_HALTED;
               end
            end
            default: begin
               state_nxt_s[t] = ST_IDLE;
            end
         endcase
      end
   end

   // Thread state and PC registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int t = 0; t < 4; t++) begin
            state_r[t] <= ST_IDLE;
            pc_r[t]    <= start_pc(2'(t));
         end
      end else begin
         for (int t = 0; t < 4; t++) begin
            state_r[t] <= state_nxt_s[t];
            pc_r[t]    <= pc_nxt_s[t];
         end
      end
   end

   // Issue slot and round-robin pointer.
   always_ff @(posedge CLK) begin
      if (RST) begin
         issue_valid_o  <= 1'b0;
         issue_thread_o <= 2'd0;
         issue_pc_o     <= {W{1'b0}};
         last_r         <= 2'd3;
      end else if (issue_s) begin
         issue_valid_o  <= 1'b1;
         issue_thread_o <= sel_s;
         issue_pc_o     <= redir_sel_s ? redirect_pc_i : pc_r[sel_s];
         last_r         <= sel_s;
      end else if (!stall_i) begin
         issue_valid_o  <= 1'b0;
      end else begin
         issue_valid_o  <= issue_valid_o;
      end
   end

   // Run status straight from the state registers.
   always_comb begin
      running_o = run_s;
      idle_o    = ~|run_s;
   end

endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

- Fine-grained, four-thread issue scheduler at the front of the pipeline, ahead of fetch/decode.
- Owns the per-thread program counters and run state.
- Each unstalled cycle it picks the next runnable thread in round-robin order and presents that thread's PC and thread ID to instruction fetch; the ID then travels with the instruction to writeback.
- Accepts PC redirects (branch/jump) and halt notifications from the execute stage.

## Interface
Parameters:
- INSTMEM_LOG2_DEEP, 8, instruction-memory address width; width of all PCs.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- thread_en_i  input  4  per-thread enable mask; bit t starts/keeps thread t.
- stall_i  input  1  pipeline stall; freezes issue.
- redirect_valid_i  input  1  PC redirect request from execute.
- redirect_thread_i  input  2  thread being redirected.
- redirect_pc_i  input  INSTMEM_LOG2_DEEP  new PC.
- halt_valid_i  input  1  halt instruction retired in execute.
- halt_thread_i  input  2  thread that halted.
- issue_valid_o  output  1  registered; issue slot holds a real instruction.
- issue_thread_o  output  2  registered; thread ID of issued slot.
- issue_pc_o  output  INSTMEM_LOG2_DEEP  registered; fetch address.
- running_o  output  4  bit t = thread t in RUN.
- idle_o  output  1  no thread in RUN (combinational from state).

## Operation
- Per-thread FSM, states IDLE, RUN, HALTED:
  - IDLE -> RUN when thread_en_i[t]=1; pc[t] loads start PC = t << (INSTMEM_LOG2_DEEP-2), i.e. 0, 64, 128, 192 at default width.
  - RUN -> HALTED on halt_valid_i with halt_thread_i=t.
  - RUN -> IDLE, or HALTED -> IDLE, when thread_en_i[t]=0. This kills the thread; HALTED stays until the enable is dropped, which re-arms it.
- Eligible set: threads in RUN, minus any thread named by a same-cycle halt (halt wins).
- Selection: round-robin pointer `last`. Priority order is last+1, last+2, last+3, last (mod 4). The first eligible thread in that order is selected.
- Issue (stall_i=0, selection exists):
  - issue_valid_o<=1, issue_thread_o<=sel, issue_pc_o<=pc[sel], last<=sel.
  - pc[sel]<=pc[sel]+1, wrapping modulo 2^INSTMEM_LOG2_DEEP (0xFF -> 0x00).
- No eligible thread, stall_i=0:
  - issue_valid_o<=0; issue_thread_o and issue_pc_o hold; last holds.
- stall_i=1:
  - All issue_* outputs hold, last holds, no PC increments.
  - Thread FSM transitions, redirects and halts still apply.
- Redirect (redirect_valid_i=1, target thread r in RUN and not halting this cycle):
  - Not selected, or stall_i=1: pc[r]<=redirect_pc_i.
  - Selected and issuing: issue_pc_o<=redirect_pc_i and pc[r]<=redirect_pc_i+1. This is a bypass, so no wrong-path PC is issued.
- Redirect to a thread not in RUN, or to a thread halting the same cycle: ignored.
- Halt to a thread not in RUN: ignored.
- Redirect and halt to different threads in the same cycle: both apply.

## Timing
- Reset values:
  - issue_valid_o=0, issue_thread_o=0, issue_pc_o=0.
  - All threads IDLE; running_o=0, idle_o=1.
  - last=3, so thread 0 has first priority; all pc[t]=start PC.
- RST has priority over every other input. Reset mid-run discards all PCs and state; the next issue needs thread_en_i to be re-sampled after reset.
- Start latency:
  - thread_en_i[t] sampled high at edge N -> RUN after edge N.
  - First issue of that thread registered at edge N+1 at the earliest.
- Redirect and halt take effect on the edge at which they are sampled. Issue at that same edge already honours them, as defined above.
- Throughput: one issue per unstalled cycle. With k threads running, each issues exactly once every k unstalled cycles.

## Test plan
- Reset, then thread_en_i=4'b0001 -> issue_valid_o=1 from the 2nd edge after enable; PCs 0,1,2,... on thread 0 each cycle. Hold 256 issues -> PC wraps 0xFF -> 0x00.
- thread_en_i=4'b1111 -> issued threads 0,1,2,3,0,... with PCs 0,64,128,192,1,65,...; stall_i high 3 cycles mid-sequence -> outputs frozen, sequence resumes without skip or repeat.
- Threads 0 and 2 running; redirect thread 2 to 0x40 in the cycle thread 2 is selected -> issue_pc_o=0x40, next thread-2 issue 0x41; redirect to IDLE thread 1 -> no effect.
- Halt thread 0 while 0 and 1 run -> thread 0 never issues again, only thread 1 issues; running_o=4'b0010. Drop then raise thread_en_i[0] -> thread 0 restarts at PC 0.
- Halt last running thread -> issue_valid_o=0 next edge, idle_o=1; simultaneous halt and redirect to that thread -> halt wins, PC unchanged.
- Assert RST mid-run with all threads active -> all outputs at reset values on the next edge; no issue until enables are re-sampled.
